// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier with a start/busy/done handshake.
// Operands are converted to magnitudes on entry, multiplied unsigned over
// WIDTH clock cycles, and the sign is restored in a final FIX cycle.
//
// Handshake: start is sampled only while the FSM is IDLE. A sampled start
// captures a, b and signed_mode, and busy rises on that same edge. busy stays
// high through RUN and FIX. done is a one-cycle pulse that marks product as
// new. start may be held high in the done cycle to chain the next job.
// start seen while busy is ignored.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     p_reg,
  output logic [WIDTH-1:0]     q_reg,
  output logic [WIDTH-1:0]     m_reg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH-1:0]     r_p;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_m;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_pq;

  // Magnitudes: negating the most negative value wraps to 2^(WIDTH-1),
  // which is exactly the unsigned magnitude we want.
  assign w_a_mag = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_b_mag = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Partial-sum add with the carry kept so it can shift into P's MSB.
  assign w_sum = r_q[0] ? ({1'b0, r_p} + {1'b0, r_m}) : {1'b0, r_p};

  assign w_pq = {r_p, r_q};

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
      r_p       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= w_a_mag;
            r_q     <= w_b_mag;
            r_p     <= '0;
            r_cnt   <= '0;
            r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_p   <= w_sum[WIDTH:1];
          r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_product <= r_neg ? (~w_pq + 1'b1) : w_pq;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
  assign p_reg   = r_p;
  assign q_reg   = r_q;
  assign m_reg   = r_m;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_shift_add_multiplier;

  logic clk;
  logic rst_n;

  // WIDTH=4 instance
  logic       start4, sm4, busy4, done4;
  logic [3:0] a4, b4, p4, q4, m4;
  logic [7:0] prod4;

  // WIDTH=8 instance
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8, p8, q8, m8;
  logic [15:0] prod8;

  int n_cmp = 0;
  int n_err = 0;

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .signed_mode(sm4), .busy(busy4), .done(done4), .product(prod4),
    .p_reg(p4), .q_reg(q4), .m_reg(m4)
  );

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .signed_mode(sm8), .busy(busy8), .done(done8), .product(prod8),
    .p_reg(p8), .q_reg(q8), .m_reg(m8)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands with start for one edge; returns #1 after the accepting edge.
  task automatic launch4(input logic [3:0] a, input logic [3:0] b, input logic sm);
    a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Wait (bounded) for done after an accept; checks edge count and product.
  // Expected edge count after the accepting edge is WIDTH+1 (WIDTH RUN + FIX).
  task automatic wait_done(input int w, input logic [15:0] exp, input string tag);
    int lat;
    lat = 0;
    while (((w == 4) ? done4 : done8) !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, w + 1);
    check({tag, "_prod"}, (w == 4) ? {8'h0, prod4} : prod8, exp);
  endtask

  // Checks that done drops on the following cycle.
  task automatic pulse_end(input int w, input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, (w == 4) ? done4 : done8, 1'b0);
  endtask

  logic [7:0] trace [4];
  int busy_cycles;
  int n_done;

  initial begin
    trace[0] = 8'h06; trace[1] = 8'h03; trace[2] = 8'h19; trace[3] = 8'h24;
    rst_n = 1'b0;
    start4 = 0; a4 = 0; b4 = 0; sm4 = 0;
    start8 = 0; a8 = 0; b8 = 0; sm8 = 0;

    // Reset state
    #2;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_prod", prod4, 0);
    check("rst_pqm", {p4, q4, m4}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 3*12 unsigned with iteration trace
    launch4(4'd3, 4'd12, 1'b0);
    busy_cycles = 1;
    check("t1_busy0", busy4, 1);
    check("t1_m", m4, 4'd3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("t1_trace%0d", i + 1), {p4, q4}, trace[i]);
      if (busy4) busy_cycles++;
    end
    @(posedge clk); #1;
    check("t1_busy_cycles", busy_cycles, 5);
    check("t1_done", done4, 1);
    check("t1_busy_end", busy4, 0);
    check("t1_prod", prod4, 8'd36);

    // Back-to-back: start during done cycle, 15*15
    launch4(4'd15, 4'd15, 1'b0);
    check("b2b_busy", busy4, 1);
    wait_done(4, 16'd225, "b2b");
    pulse_end(4, "b2b");

    // Signed cases
    launch4(4'hD, 4'd5, 1'b1);
    wait_done(4, 16'h00F1, "s_m3x5");
    check("s_m3x5_m", m4, 4'd3);
    pulse_end(4, "s_m3x5");
    launch4(4'h8, 4'h8, 1'b1);
    check("s_hold_prod", prod4, 8'hF1);
    wait_done(4, 16'h0040, "s_m8xm8");
    pulse_end(4, "s_m8xm8");
    launch4(4'h8, 4'h7, 1'b1);
    wait_done(4, 16'h00C8, "s_m8x7");
    pulse_end(4, "s_m8x7");

    // Start re-asserted mid-RUN is ignored: 5*6 = 30
    launch4(4'd5, 4'd6, 1'b0);
    @(posedge clk); #1;
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin
        n_done++;
        check("mid_prod", prod4, 8'd30);
      end
      @(posedge clk); #1;
    end
    check("mid_done_count", n_done, 1);

    // Async reset mid-RUN, then 2*6
    launch4(4'd9, 4'd9, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_prod", prod4, 0);
    check("arst_pqm", {p4, q4, m4}, 0);
    @(negedge clk); rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4) n_done++;
    end
    check("arst_no_done", n_done, 0);
    launch4(4'd2, 4'd6, 1'b0);
    wait_done(4, 16'd12, "arst_2x6");

    // WIDTH=8
    launch8(8'd255, 8'd255, 1'b0);
    wait_done(8, 16'hFE01, "w8_max");
    pulse_end(8, "w8_max");
    launch8(8'h80, 8'h80, 1'b1);
    wait_done(8, 16'h4000, "w8_min");
    check("w8_min_m", m8, 8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
